imm_extend: RTL and testbench

- Immediate-field extension unit for the multi-cycle processor datapath.
- Takes an 8-bit instruction immediate field and a 2-bit length select.
- Produces an 8-bit sign- or zero-extended operand for the ALU or address path.
- Output is registered, so it lines up with the datapath's per-state register boundaries.

---
 rtl/imm_extend.sv | 65 ++++++
 tb/tb_imm_extend.sv | 92 +++++++++
 2 files changed

// File: rtl/imm_extend.sv
// rtl/imm_extend.sv - registered immediate-field sign/zero extension unit
//
// Purpose:
//   Extends a right-aligned immediate field to DATA_W bits and registers the
//   result, so the extended operand is valid one clock after capture.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   qualifies in/len_sel for capture this cycle
//   in        in   [DATA_W-1:0] raw immediate field, LSB at bit 0
//   len_sel   in   [1:0] 00 short sext, 01 medium sext, 10 short zext, 11 pass
//   out       out  [DATA_W-1:0] registered extended value
//   out_valid out  out was captured on the previous edge
//   out_neg   out  registered MSB of out

module imm_extend #(
  parameter int DATA_W  = 8,
  parameter int SHORT_W = 4,
  parameter int MID_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in,
  input  logic [1:0]        len_sel,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              out_neg
);

  localparam logic [1:0] SEL_SHORT_S = 2'b00;
  localparam logic [1:0] SEL_MID_S   = 2'b01;
  localparam logic [1:0] SEL_SHORT_Z = 2'b10;

  logic [DATA_W-1:0] ext;

  // Bits above the selected field never reach ext, so X on them cannot leak.
  always_comb begin
    ext = in;
    case (len_sel)
      SEL_SHORT_S: ext = {{(DATA_W-SHORT_W){in[SHORT_W-1]}}, in[SHORT_W-1:0]};
      SEL_MID_S:   ext = {{(DATA_W-MID_W){in[MID_W-1]}}, in[MID_W-1:0]};
      SEL_SHORT_Z: ext = {{(DATA_W-SHORT_W){1'b0}}, in[SHORT_W-1:0]};
      default:     ext = in;
    endcase
  end

  // out/out_neg hold when idle; only out_valid drops so consumers see
  // exactly one valid cycle per capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_neg   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out     <= ext;
        out_neg <= ext[DATA_W-1];
      end
    end
  end

endmodule

// File: tb/tb_imm_extend.sv
// tb/tb_imm_extend.sv - directed self-checking bench for imm_extend

module tb_imm_extend;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in;
  logic [1:0] len_sel;
  logic [7:0] out;
  logic       out_valid;
  logic       out_neg;

  int n_checks = 0;
  int n_errors = 0;

  imm_extend dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in),
    .len_sel   (len_sel),
    .out       (out),
    .out_valid (out_valid),
    .out_neg   (out_neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then sample just after the edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic [1:0] s);
    rst      = r;
    in_valid = v;
    in       = d;
    len_sel  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] e_out,
                            input logic e_valid, input logic e_neg);
    check({tag, ".out"},   out,             e_out);
    check({tag, ".valid"}, {7'd0, out_valid}, {7'd0, e_valid});
    check({tag, ".neg"},   {7'd0, out_neg},   {7'd0, e_neg});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in = 8'h00; len_sel = 2'b00;
    #2;

    // Reset dominates in_valid
    step(1'b1, 1'b1, 8'hFF, 2'b11); expect_out("rst0", 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 2'b11); expect_out("rst1", 8'h00, 1'b0, 1'b0);

    // Short sign-extend
    step(1'b0, 1'b1, 8'h0A, 2'b00); expect_out("ss_neg", 8'hFA, 1'b1, 1'b1);
    step(1'b0, 1'b1, 8'h07, 2'b00); expect_out("ss_pos", 8'h07, 1'b1, 1'b0);

    // Medium sign-extend, upper input bits ignored
    step(1'b0, 1'b1, 8'h25, 2'b01); expect_out("ms_neg", 8'hE5, 1'b1, 1'b1);
    step(1'b0, 1'b1, 8'hDA, 2'b01); expect_out("ms_pos", 8'h1A, 1'b1, 1'b0);

    // Zero-extend and pass-through
    step(1'b0, 1'b1, 8'hFA, 2'b10); expect_out("zext", 8'h0A, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'h81, 2'b11); expect_out("pass", 8'h81, 1'b1, 1'b1);
    step(1'b0, 1'b1, 8'h7F, 2'b11); expect_out("pass_pos", 8'h7F, 1'b1, 1'b0);

    // Hold while idle
    step(1'b0, 1'b1, 8'h0A, 2'b00); expect_out("cap", 8'hFA, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h33, 2'b11); expect_out("hold0", 8'hFA, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 2'b10); expect_out("hold1", 8'hFA, 1'b0, 1'b1);

    // Streaming, then reset on third cycle discards the capture
    step(1'b0, 1'b1, 8'h08, 2'b00); expect_out("str0", 8'hF8, 1'b1, 1'b1);
    step(1'b0, 1'b1, 8'h3F, 2'b10); expect_out("str1", 8'h0F, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h20, 2'b01); expect_out("str_rst", 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h55, 2'b11); expect_out("post_rst", 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h20, 2'b01); expect_out("resume", 8'hE0, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
